vector_mem_sequencer: RTL and testbench

Multi-cycle vector load/store sequencer sitting between the vector register file and the single-port data memory. On `start` it captures a base address, optional stride and (for stores) a LANES-wide operand vector. It then issues one scalar memory request per lane over a valid/ready handshake and, for loads, assembles the returned words into a vector result. It replaces the combinational unit-stride address generator with a parametrised, backpressure-aware sequencer.

---
 rtl/vector_mem_sequencer.sv | 118 +++++++++++
 tb/tb_vector_mem_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - per-lane vector load/store sequencer over a valid/ready memory port.
// Optional VLSU_STRIDE_EN enables a captured signed stride; otherwise lanes are unit-stride.
module vector_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         is_store,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W-1:0]            stride,
  input  logic [LANES-1:0][DATA_W-1:0] store_data,
  output logic                         busy,
  output logic                         done,
  output logic [LANES-1:0][DATA_W-1:0] load_data,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  input  logic                         mem_rvalid,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IW = $clog2(LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                       state, state_nxt;
  logic [LW-1:0]                iidx;
  logic [IW-1:0]                ridx;
  logic [ADDR_W-1:0]            addr;
  logic [ADDR_W-1:0]            step;
  logic                         st;
  logic [LANES-1:0][DATA_W-1:0] sdata;
  logic                         launch;
  logic                         accept;
  logic                         last_accept;
  logic                         ret;
  logic                         loads_complete;

`ifdef VLSU_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (launch) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  logic unused_stride;

  assign unused_stride = ^stride;
  assign step          = ADDR_W'(1);
`endif

  assign launch      = (state == S_IDLE) && start;
  assign accept      = (state == S_ISSUE) && mem_ready;
  assign last_accept = accept && (iidx == LW'(LANES - 1));
  // Returns only count for loads in flight and never past the last lane.
  assign ret = ((state == S_ISSUE) || (state == S_WAIT)) && !st && mem_rvalid &&
               (ridx != IW'(LANES));
  assign loads_complete = (ridx + IW'(ret)) == IW'(LANES);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (last_accept) state_nxt = (st || loads_complete) ? S_DONE : S_WAIT;
      S_WAIT:  if (loads_complete) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      iidx      <= '0;
      ridx      <= '0;
      addr      <= '0;
      st        <= 1'b0;
      sdata     <= '0;
      load_data <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        st    <= is_store;
        sdata <= store_data;
        iidx  <= '0;
        ridx  <= '0;
        addr  <= base_addr;
      end else if (accept) begin
        iidx <= iidx + LW'(1);
        addr <= addr + step;
      end
      if (ret) begin
        load_data[ridx[LW-1:0]] <= mem_rdata;
        ridx                    <= ridx + IW'(1);
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_req   = (state == S_ISSUE);
  assign mem_we    = mem_req && st;
  assign mem_addr  = mem_req ? addr : '0;
  assign mem_wdata = (mem_req && st) ? sdata[iidx] : '0;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb/tb_vector_mem_sequencer.sv - directed bench for vector_mem_sequencer (LANES=4, 32-bit).
module tb_vector_mem_sequencer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             is_store;
  logic [31:0]      base_addr;
  logic [31:0]      stride;
  logic [3:0][31:0] store_data;
  logic             busy;
  logic             done;
  logic [3:0][31:0] load_data;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ready;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] sv [4] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
  logic [31:0] lt [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
  logic [31:0] lt2[4] = '{32'h5001, 32'h5002, 32'h5003, 32'h5004};
  int          bp_lane[6] = '{0, 1, 1, 1, 2, 3};
`ifdef VLSU_STRIDE_EN
  logic [31:0] str_addr[4] = '{32'h4, 32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8};
`else
  logic [31:0] str_addr[4] = '{32'h4, 32'h5, 32'h6, 32'h7};
`endif

  vector_mem_sequencer #(.LANES(4), .DATA_W(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .base_addr  (base_addr),
    .stride     (stride),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic st, input logic [31:0] b, input logic [31:0] s);
    is_store  = st;
    base_addr = b;
    stride    = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic check_lanes(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    check($sformatf("%s_l0", tag), load_data[0], e0);
    check($sformatf("%s_l1", tag), load_data[1], e1);
    check($sformatf("%s_l2", tag), load_data[2], e2);
    check($sformatf("%s_l3", tag), load_data[3], e3);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    is_store   = 1'b0;
    base_addr  = '0;
    stride     = 32'd1;
    store_data = '0;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check_lanes("rst_ld", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load, base 0x20, return latency 2
    launch(1'b0, 32'h20, 32'd1);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("ld_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 7});
      check($sformatf("ld_done_c%0d", c), {31'd0, done}, {31'd0, c == 7});
      check($sformatf("ld_req_c%0d", c), {31'd0, mem_req}, {31'd0, c <= 4});
      if (c <= 4) begin
        check($sformatf("ld_addr_c%0d", c), mem_addr, 32'h20 + 32'(c - 1));
        check($sformatf("ld_we_c%0d", c), {31'd0, mem_we}, 32'd0);
      end
      mem_rvalid = (c >= 3) && (c <= 6);
      mem_rdata  = mem_rvalid ? lt[c-3] : 32'hX;
      tick();
    end
    mem_rvalid = 1'b0;
    check_lanes("ld_res", 32'd11, 32'd22, 32'd33, 32'd44);

    // Unit-stride store, base 0x100
    for (int i = 0; i < 4; i++) store_data[i] = sv[i];
    launch(1'b1, 32'h100, 32'd1);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("st_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 5});
      check($sformatf("st_done_c%0d", c), {31'd0, done}, {31'd0, c == 5});
      check($sformatf("st_req_c%0d", c), {31'd0, mem_req}, {31'd0, c <= 4});
      if (c <= 4) begin
        check($sformatf("st_we_c%0d", c), {31'd0, mem_we}, 32'd1);
        check($sformatf("st_addr_c%0d", c), mem_addr, 32'h100 + 32'(c - 1));
        check($sformatf("st_wdata_c%0d", c), mem_wdata, sv[c-1]);
      end
      tick();
    end
    check_lanes("st_keep", 32'd11, 32'd22, 32'd33, 32'd44);

    // Store with mem_ready low in cycles 2-3
    launch(1'b1, 32'h100, 32'd1);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("bp_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 7});
      check($sformatf("bp_done_c%0d", c), {31'd0, done}, {31'd0, c == 7});
      if (c <= 6) begin
        check($sformatf("bp_req_c%0d", c), {31'd0, mem_req}, 32'd1);
        check($sformatf("bp_addr_c%0d", c), mem_addr, 32'h100 + 32'(bp_lane[c-1]));
        check($sformatf("bp_wdata_c%0d", c), mem_wdata, sv[bp_lane[c-1]]);
      end
      mem_ready = !((c == 2) || (c == 3));
      tick();
    end
    mem_ready = 1'b1;

    // Stride -4 from base 0x4 (wraps when strided)
    launch(1'b1, 32'h4, 32'hFFFFFFFC);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) check($sformatf("str_addr_c%0d", c), mem_addr, str_addr[c-1]);
      check($sformatf("str_done_c%0d", c), {31'd0, done}, {31'd0, c == 5});
      tick();
    end

    // Asynchronous reset in cycle 2 of a load
    launch(1'b0, 32'h40, 32'd1);
    tick();
    check("rl_req_c2", {31'd0, mem_req}, 32'd1);
    check("rl_addr_c2", mem_addr, 32'h41);
    #2;
    rst_n = 1'b0;
    #1;
    check("rl_busy", {31'd0, busy}, 32'd0);
    check("rl_done", {31'd0, done}, 32'd0);
    check("rl_req", {31'd0, mem_req}, 32'd0);
    check("rl_we", {31'd0, mem_we}, 32'd0);
    check("rl_addr", mem_addr, 32'd0);
    check("rl_wdata", mem_wdata, 32'd0);
    check_lanes("rl_ld", 0, 0, 0, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    mem_rvalid = 1'b0;
    check("rl_idle_busy", {31'd0, busy}, 32'd0);
    check_lanes("rl_ign", 0, 0, 0, 0);

    // Fresh load after reset, latency 1
    launch(1'b0, 32'h80, 32'd1);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) check($sformatf("l1_addr_c%0d", c), mem_addr, 32'h80 + 32'(c - 1));
      check($sformatf("l1_done_c%0d", c), {31'd0, done}, {31'd0, c == 6});
      mem_rvalid = (c >= 2) && (c <= 5);
      mem_rdata  = mem_rvalid ? lt2[c-2] : 32'hX;
      tick();
    end
    mem_rvalid = 1'b0;
    check_lanes("l1_res", lt2[0], lt2[1], lt2[2], lt2[3]);

    // Start pulsed while busy, then stray return in IDLE
    launch(1'b1, 32'h200, 32'd1);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        check($sformatf("sb_addr_c%0d", c), mem_addr, 32'h200 + 32'(c - 1));
        check($sformatf("sb_we_c%0d", c), {31'd0, mem_we}, 32'd1);
      end
      check($sformatf("sb_done_c%0d", c), {31'd0, done}, {31'd0, c == 5});
      check($sformatf("sb_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 5});
      start     = (c == 2);
      is_store  = (c == 2) ? 1'b0 : 1'b1;
      base_addr = (c == 2) ? 32'h300 : 32'h200;
      tick();
    end
    start      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("sb_idle_busy", {31'd0, busy}, 32'd0);
    check("sb_idle_req", {31'd0, mem_req}, 32'd0);
    check_lanes("sb_keep", lt2[0], lt2[1], lt2[2], lt2[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
